// File: rtl/dsa_sched_pkg.sv
// dsa_sched_pkg: shared state encoding and default widths for the lane scheduler
//   state_t         : S_IDLE, S_DISPATCH, S_DRAIN, S_DONE
//   DEF_NUM_LANES   : default lane count
//   DEF_COORD_W     : default coordinate / dimension width
//   DEF_IDX_W       : default linear index / counter width
package dsa_sched_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_COORD_W   = 16;
    localparam int DEF_IDX_W     = 32;
endpackage

// File: rtl/dsa_rr_arbiter.sv
// dsa_rr_arbiter: combinational masked-priority round-robin grant
//   free  in  NUM_LANES : lanes available for a new pixel
//   ptr   in  PTR_W     : lane with highest priority this cycle
//   grant out NUM_LANES : one-hot grant, all-zero when nothing is free
module dsa_rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] free,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant
);
    logic [NUM_LANES-1:0] masked;
    // lanes at or above ptr win first; otherwise wrap to the lowest free lane
    assign masked = free & ~((NUM_LANES'(1) << ptr) - NUM_LANES'(1));
    assign grant  = |masked ? masked & (~masked + NUM_LANES'(1))
                            : free & (~free + NUM_LANES'(1));
endmodule

// File: rtl/dsa_lane_scheduler.sv
// dsa_lane_scheduler: raster-order pixel dispatch across interpolation lanes
//   start                 in  : begin a frame (honoured only when idle)
//   out_width/out_height  in  : frame size, latched on an accepted start
//   lane_done             in  : per-lane completion pulse
//   lane_start            out : one-hot dispatch of the current pixel
//   lane_x/lane_y         out : coordinates of the pixel on offer
//   lane_index            out : linear index y*width+x of that pixel
//   busy/ready/done       out : frame status decoded from the state
//   pixels_done           out : completions accepted in the current/last frame
module dsa_lane_scheduler
    import dsa_sched_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int PTR_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [COORD_W-1:0]   out_width,
    input  logic [COORD_W-1:0]   out_height,
    input  logic [NUM_LANES-1:0] lane_done,
    output logic [NUM_LANES-1:0] lane_start,
    output logic [COORD_W-1:0]   lane_x,
    output logic [COORD_W-1:0]   lane_y,
    output logic [IDX_W-1:0]     lane_index,
    output logic                 busy,
    output logic                 ready,
    output logic                 done,
    output logic [IDX_W-1:0]     pixels_done
);
    state_t               state;
    logic [COORD_W-1:0]   w, h;
    logic [IDX_W-1:0]     disp_cnt, total, done_cnt, pd_next;
    logic [NUM_LANES-1:0] free, grant, acc;
    logic [PTR_W-1:0]     rr_ptr, gi;

    dsa_rr_arbiter #(.NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_arb (
        .free  (free),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign total      = IDX_W'(w) * IDX_W'(h);
    // completions from lanes already marked free are stale and dropped
    assign acc        = lane_done & ~free;
    assign lane_start = (state == S_DISPATCH) ? grant : '0;
    assign busy       = (state == S_DISPATCH) || (state == S_DRAIN);
    assign ready      = state == S_IDLE;
    assign done       = state == S_DONE;
    assign pd_next    = pixels_done + done_cnt;

    always_comb begin
        gi       = '0;
        done_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            gi       = grant[i] ? PTR_W'(i) : gi;
            done_cnt = done_cnt + IDX_W'(acc[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            w           <= '0;
            h           <= '0;
            lane_x      <= '0;
            lane_y      <= '0;
            lane_index  <= '0;
            disp_cnt    <= '0;
            pixels_done <= '0;
            free        <= '1;
            rr_ptr      <= '0;
        end else begin
            free        <= (free & ~lane_start) | acc;
            pixels_done <= pd_next;
            case (state)
                S_IDLE: if (start) begin
                    w           <= out_width;
                    h           <= out_height;
                    lane_x      <= '0;
                    lane_y      <= '0;
                    lane_index  <= '0;
                    disp_cnt    <= '0;
                    pixels_done <= '0;
                    state       <= (out_width == '0 || out_height == '0) ? S_DONE : S_DISPATCH;
                end
                S_DISPATCH: if (|lane_start) begin
                    lane_x     <= (lane_x == w - 1'b1) ? '0 : lane_x + 1'b1;
                    lane_y     <= (lane_x == w - 1'b1) ? lane_y + 1'b1 : lane_y;
                    lane_index <= lane_index + 1'b1;
                    disp_cnt   <= disp_cnt + 1'b1;
                    rr_ptr     <= (gi == PTR_W'(NUM_LANES - 1)) ? '0 : gi + 1'b1;
                    if (disp_cnt + 1'b1 == total) state <= S_DRAIN;
                end
                // the completion accepted on this edge counts toward the exit
                S_DRAIN: if (pd_next == total) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsa_lane_scheduler.sv
// tb_dsa_lane_scheduler: directed checks of the lane scheduler with 4-lane and 2-lane instances
module tb_dsa_lane_scheduler;
    localparam int CW = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic [CW-1:0] out_width = '0;
    logic [CW-1:0] out_height = '0;
    logic [3:0]    ld = '0;
    logic [3:0]    inject = '0;

    logic          start4, start2;
    logic [3:0]    ld4, ls4;
    logic [1:0]    ld2, ls2;
    logic [CW-1:0] x4, y4, x2, y2;
    logic [IW-1:0] i4, i2, pd4, pd2;
    logic          b4, r4, d4, b2, r2, d2;

    logic [3:0]    m_ls;
    logic [CW-1:0] m_x, m_y;
    logic [IW-1:0] m_idx, m_pd;
    logic          m_busy, m_ready, m_done;

    assign start4  = start & ~sel;
    assign start2  = start & sel;
    assign ld4     = sel ? 4'b0 : ld;
    assign ld2     = sel ? ld[1:0] : 2'b0;
    assign m_ls    = sel ? {2'b0, ls2} : ls4;
    assign m_x     = sel ? x2 : x4;
    assign m_y     = sel ? y2 : y4;
    assign m_idx   = sel ? i2 : i4;
    assign m_pd    = sel ? pd2 : pd4;
    assign m_busy  = sel ? b2 : b4;
    assign m_ready = sel ? r2 : r4;
    assign m_done  = sel ? d2 : d4;

    dsa_lane_scheduler #(.NUM_LANES(4), .COORD_W(CW), .IDX_W(IW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .out_width(out_width), .out_height(out_height),
        .lane_done(ld4), .lane_start(ls4), .lane_x(x4), .lane_y(y4), .lane_index(i4),
        .busy(b4), .ready(r4), .done(d4), .pixels_done(pd4)
    );

    dsa_lane_scheduler #(.NUM_LANES(2), .COORD_W(CW), .IDX_W(IW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .out_width(out_width), .out_height(out_height),
        .lane_done(ld2), .lane_start(ls2), .lane_x(x2), .lane_y(y2), .lane_index(i2),
        .busy(b2), .ready(r2), .done(d2), .pixels_done(pd2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int viol = 0;
    int n_done = 0;
    int done_cyc = -1;
    int dly [4];
    bit pend [4];
    int cnt [4];
    logic [3:0] busy_m = '0;
    int q_lane [$];
    int q_x [$];
    int q_y [$];
    int q_idx [$];
    int q_cyc [$];

    // lane model: records dispatches, flags grants to lanes it believes busy,
    // and answers each dispatch with lane_done after that lane's delay
    initial begin
        logic [3:0] nxt;
        for (int i = 0; i < 4; i++) begin
            dly[i] = 0;
            pend[i] = 0;
            cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (m_ls != 4'b0) begin
                if ((m_ls & (m_ls - 4'd1)) != 4'b0 || (m_ls & busy_m) != 4'b0) viol++;
                for (int i = 0; i < 4; i++)
                    if (m_ls[i]) begin
                        q_lane.push_back(i);
                        q_x.push_back(int'(m_x));
                        q_y.push_back(int'(m_y));
                        q_idx.push_back(int'(m_idx));
                        q_cyc.push_back(cyc);
                    end
            end
            if (m_done) begin
                n_done++;
                done_cyc = cyc;
            end
            nxt = inject;
            for (int i = 0; i < 4; i++)
                if (pend[i]) begin
                    if (cnt[i] == 0) begin
                        nxt[i] = 1'b1;
                        pend[i] = 0;
                    end else cnt[i]--;
                end
            for (int i = 0; i < 4; i++)
                if (m_ls[i]) begin
                    pend[i] = 1;
                    cnt[i] = dly[i];
                end
            busy_m = (busy_m & ~nxt) | m_ls;
            if (!rst_n) begin
                busy_m = '0;
                for (int i = 0; i < 4; i++) pend[i] = 0;
            end
            ld = nxt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        q_lane.delete();
        q_x.delete();
        q_y.delete();
        q_idx.delete();
        q_cyc.delete();
        viol = 0;
        n_done = 0;
        done_cyc = -1;
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0;
        dly[1] = d1;
        dly[2] = d2;
        dly[3] = d3;
    endtask

    // start accepted at edge E0; c0 is the monitor cycle just before E0
    task automatic kick(input int w, input int h, output int c0);
        out_width = CW'(w);
        out_height = CW'(h);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = n_done;
        for (int i = 0; i < budget && n_done == base; i++) begin
            @(negedge clk); #1;
        end
        check({tag, "_done_seen"}, 64'(n_done), 64'(base + 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int c0;
        int exp_lane [6];
        int exp_cyc [6];
        exp_lane = '{0, 1, 0, 0, 0, 0};
        exp_cyc  = '{1, 2, 3, 5, 7, 9};

        // reset state
        idle(3);
        check("rst_ready", 64'(m_ready), 64'd1);
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_done", 64'(m_done), 64'd0);
        check("rst_lane_start", 64'(m_ls), 64'd0);
        check("rst_pixels_done", m_pd, 64'd0);
        check("rst_index", m_idx, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // 2x2, 4 lanes, immediate completions
        sel = 1'b0;
        set_dly(0, 0, 0, 0);
        clear_log();
        kick(2, 2, c0);
        wait_done("t1", 40);
        check("t1_done_cyc", 64'(done_cyc), 64'(c0 + 6));
        check("t1_disp_count", 64'(q_lane.size()), 64'd4);
        for (int k = 0; k < q_lane.size() && k < 4; k++) begin
            check($sformatf("t1_lane%0d", k), 64'(q_lane[k]), 64'(k));
            check($sformatf("t1_idx%0d", k), 64'(q_idx[k]), 64'(k));
            check($sformatf("t1_x%0d", k), 64'(q_x[k]), 64'(k % 2));
            check($sformatf("t1_y%0d", k), 64'(q_y[k]), 64'(k / 2));
            check($sformatf("t1_cyc%0d", k), 64'(q_cyc[k]), 64'(c0 + 1 + k));
        end
        check("t1_pixels_done", m_pd, 64'd4);
        idle(1);
        check("t1_ready_after", 64'(m_ready), 64'd1);
        check("t1_done_once", 64'(n_done), 64'd1);

        // 3x2, 2 lanes, lane 1 slow
        sel = 1'b1;
        set_dly(0, 10, 0, 0);
        idle(1);
        clear_log();
        kick(3, 2, c0);
        wait_done("t2", 60);
        check("t2_done_cyc", 64'(done_cyc), 64'(c0 + 14));
        check("t2_disp_count", 64'(q_lane.size()), 64'd6);
        for (int k = 0; k < q_lane.size() && k < 6; k++) begin
            check($sformatf("t2_lane%0d", k), 64'(q_lane[k]), 64'(exp_lane[k]));
            check($sformatf("t2_idx%0d", k), 64'(q_idx[k]), 64'(k));
            check($sformatf("t2_x%0d", k), 64'(q_x[k]), 64'(k % 3));
            check($sformatf("t2_y%0d", k), 64'(q_y[k]), 64'(k / 3));
            check($sformatf("t2_cyc%0d", k), 64'(q_cyc[k]), 64'(c0 + exp_cyc[k]));
        end
        check("t2_no_busy_grant", 64'(viol), 64'd0);
        check("t2_pixels_done", m_pd, 64'd6);

        // zero-width frame
        sel = 1'b0;
        set_dly(0, 0, 0, 0);
        idle(1);
        clear_log();
        kick(0, 5, c0);
        wait_done("t3", 10);
        check("t3_done_cyc", 64'(done_cyc), 64'(c0 + 1));
        idle(3);
        check("t3_no_dispatch", 64'(q_lane.size()), 64'd0);
        check("t3_pixels_done", m_pd, 64'd0);
        check("t3_ready", 64'(m_ready), 64'd1);

        // start pulsed mid-frame is ignored
        set_dly(2, 2, 2, 2);
        clear_log();
        kick(2, 2, c0);
        out_width = CW'(5);
        out_height = CW'(5);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t4", 40);
        check("t4_done_cyc", 64'(done_cyc), 64'(c0 + 8));
        idle(3);
        check("t4_disp_count", 64'(q_lane.size()), 64'd4);
        for (int k = 0; k < q_idx.size() && k < 4; k++)
            check($sformatf("t4_idx%0d", k), 64'(q_idx[k]), 64'(k));
        check("t4_pixels_done", m_pd, 64'd4);
        check("t4_done_once", 64'(n_done), 64'd1);

        // reset mid-frame, stale completions afterwards
        set_dly(50, 50, 50, 50);
        clear_log();
        kick(2, 2, c0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("t5_lane_start", 64'(m_ls), 64'd0);
        check("t5_busy", 64'(m_busy), 64'd0);
        check("t5_ready", 64'(m_ready), 64'd1);
        check("t5_done", 64'(m_done), 64'd0);
        check("t5_x", 64'(m_x), 64'd0);
        check("t5_y", 64'(m_y), 64'd0);
        check("t5_index", m_idx, 64'd0);
        check("t5_pd_rst", m_pd, 64'd0);
        @(posedge clk); #1 inject = 4'b0111;
        @(posedge clk); #1 inject = 4'b0000;
        idle(2);
        check("t5_stale_ignored", m_pd, 64'd0);
        set_dly(0, 0, 0, 0);
        clear_log();
        kick(2, 2, c0);
        wait_done("t5", 40);
        check("t5_disp_count", 64'(q_lane.size()), 64'd4);
        check("t5_pixels_done", m_pd, 64'd4);
        check("t5_no_busy_grant", 64'(viol), 64'd0);

        // completions from free lanes, idle then mid-dispatch
        idle(2);
        @(posedge clk); #1 inject = 4'b1111;
        @(posedge clk); #1 inject = 4'b0000;
        idle(2);
        check("t6_idle_pd", m_pd, 64'd4);
        check("t6_idle_ready", 64'(m_ready), 64'd1);
        set_dly(20, 20, 20, 20);
        clear_log();
        kick(2, 3, c0);
        @(posedge clk); #1 inject = 4'b1000;
        @(posedge clk); #1 inject = 4'b0000;
        while (cyc < c0 + 7) begin
            @(negedge clk); #1;
        end
        check("t6_stall_disp", 64'(q_lane.size()), 64'd4);
        check("t6_stall_pd", m_pd, 64'd0);
        wait_done("t6", 100);
        check("t6_disp_count", 64'(q_lane.size()), 64'd6);
        check("t6_pixels_done", m_pd, 64'd6);
        check("t6_no_busy_grant", 64'(viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
